id_ex_reg: RTL and testbench

ID/EX pipeline register of the MIPS pipeline. It sits directly downstream of the main decoder and register file. Each cycle it captures the decode-stage control bundle and operands and presents them to the execute stage. It also contains the load-use hazard detector: it generates `StallD` for the fetch/decode registers, inserts bubbles, and counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_reg_if.sv | 56 +++++
 rtl/id_ex_reg.sv | 97 +++++++++
 tb/tb_id_ex_reg.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline bundle: decode-side control/operands in, execute-side
// registered copies out, plus the load-use stall request and bubble counter.
//   master : decode/execute environment (drives D fields and FlushE)
//   slave  : the id_ex_reg itself (drives E fields, StallD, BubbleCount)
interface id_ex_reg_if #(
    parameter int unsigned CNT_W = 16
);
    // Decode-stage side
    logic             FlushE;
    logic             ValidD;
    logic             RegWriteD;
    logic             MemtoRegD;
    logic             MemWriteD;
    logic             ALUSrcD;
    logic             RegDstD;
    logic [2:0]       ALUOpD;
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic [4:0]       RdD;
    logic [31:0]      RD1D;
    logic [31:0]      RD2D;
    logic [31:0]      SignImmD;

    // Execute-stage side
    logic             RegWriteE;
    logic             MemtoRegE;
    logic             MemWriteE;
    logic             ALUSrcE;
    logic             RegDstE;
    logic [2:0]       ALUOpE;
    logic [4:0]       RsE;
    logic [4:0]       RtE;
    logic [4:0]       RdE;
    logic [31:0]      RD1E;
    logic [31:0]      RD2E;
    logic [31:0]      SignImmE;
    logic             ValidE;

    // Hazard / monitoring
    logic             StallD;
    logic [CNT_W-1:0] BubbleCount;

    modport master (
        output FlushE, ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
               ALUOpD, RsD, RtD, RdD, RD1D, RD2D, SignImmD,
        input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUOpE,
               RsE, RtE, RdE, RD1E, RD2E, SignImmE, ValidE, StallD, BubbleCount
    );

    modport slave (
        input  FlushE, ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
               ALUOpD, RsD, RtD, RdD, RD1D, RD2D, SignImmD,
        output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUOpE,
               RsE, RtE, RdE, RD1E, RD2E, SignImmE, ValidE, StallD, BubbleCount
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decode bundle each cycle, inserts a bubble on FlushE or a
// load-use hit, raises StallD combinationally for the hit, and keeps a
// saturating count of inserted bubbles.
// Ports:
//   clk   - pipeline clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - id_ex_reg_if slave modport (D inputs, E outputs, StallD, BubbleCount)
module id_ex_reg #(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_reg_if.slave  bus
);

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sign_imm;
        logic        valid;
    } stage_t;

    stage_t           d_stage;
    stage_t           e_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             lwstall;
    logic             bubble;

    // Assemble the decode bundle
    always_comb begin
        d_stage           = '0;
        d_stage.reg_write = bus.RegWriteD;
        d_stage.mem_to_reg= bus.MemtoRegD;
        d_stage.mem_write = bus.MemWriteD;
        d_stage.alu_src   = bus.ALUSrcD;
        d_stage.reg_dst   = bus.RegDstD;
        d_stage.alu_op    = bus.ALUOpD;
        d_stage.rs        = bus.RsD;
        d_stage.rt        = bus.RtD;
        d_stage.rd        = bus.RdD;
        d_stage.rd1       = bus.RD1D;
        d_stage.rd2       = bus.RD2D;
        d_stage.sign_imm  = bus.SignImmD;
        d_stage.valid     = bus.ValidD;
    end

    // Load in EX writes rt; a dependent decode instruction must wait one cycle.
    // Loads targeting $0 never stall.
    always_comb begin
        lwstall = bus.ValidD & e_q.valid & e_q.mem_to_reg & e_q.reg_write &
                  (e_q.rt != 5'd0) &
                  ((e_q.rt == bus.RsD) | (e_q.rt == bus.RtD));
        bubble  = bus.FlushE | lwstall;
    end

    // Pipeline register and saturating bubble counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q          <= '0;
            bubble_cnt_q <= '0;
        end else if (bubble) begin
            e_q <= '0;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            e_q <= d_stage;
        end
    end

    assign bus.RegWriteE   = e_q.reg_write;
    assign bus.MemtoRegE   = e_q.mem_to_reg;
    assign bus.MemWriteE   = e_q.mem_write;
    assign bus.ALUSrcE     = e_q.alu_src;
    assign bus.RegDstE     = e_q.reg_dst;
    assign bus.ALUOpE      = e_q.alu_op;
    assign bus.RsE         = e_q.rs;
    assign bus.RtE         = e_q.rt;
    assign bus.RdE         = e_q.rd;
    assign bus.RD1E        = e_q.rd1;
    assign bus.RD2E        = e_q.rd2;
    assign bus.SignImmE    = e_q.sign_imm;
    assign bus.ValidE      = e_q.valid;
    assign bus.StallD      = lwstall;
    assign bus.BubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg (CNT_W = 4). Each driven cycle pushes the
// expected E bundle and counter onto a scoreboard queue; they are popped and
// compared one edge later. StallD is compared in the drive cycle.
module tb_id_ex_reg;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sign_imm;
        logic        valid;
    } stage_t;

    typedef struct packed {
        stage_t           e;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    id_ex_reg_if #(.CNT_W(CNT_W)) bus ();

    id_ex_reg #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t             sb_q[$];
    stage_t           m_e;
    logic [CNT_W-1:0] m_cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stage_t d_now();
        stage_t s;
        s.reg_write  = bus.RegWriteD;
        s.mem_to_reg = bus.MemtoRegD;
        s.mem_write  = bus.MemWriteD;
        s.alu_src    = bus.ALUSrcD;
        s.reg_dst    = bus.RegDstD;
        s.alu_op     = bus.ALUOpD;
        s.rs         = bus.RsD;
        s.rt         = bus.RtD;
        s.rd         = bus.RdD;
        s.rd1        = bus.RD1D;
        s.rd2        = bus.RD2D;
        s.sign_imm   = bus.SignImmD;
        s.valid      = bus.ValidD;
        return s;
    endfunction

    function automatic stage_t e_now();
        stage_t s;
        s.reg_write  = bus.RegWriteE;
        s.mem_to_reg = bus.MemtoRegE;
        s.mem_write  = bus.MemWriteE;
        s.alu_src    = bus.ALUSrcE;
        s.reg_dst    = bus.RegDstE;
        s.alu_op     = bus.ALUOpE;
        s.rs         = bus.RsE;
        s.rt         = bus.RtE;
        s.rd         = bus.RdE;
        s.rd1        = bus.RD1E;
        s.rd2        = bus.RD2E;
        s.sign_imm   = bus.SignImmE;
        s.valid      = bus.ValidE;
        return s;
    endfunction

    task automatic set_d(input logic valid, input logic rw, input logic m2r, input logic mw,
                         input logic [2:0] aluop, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic flush);
        bus.ValidD    = valid;
        bus.RegWriteD = rw;
        bus.MemtoRegD = m2r;
        bus.MemWriteD = mw;
        bus.ALUSrcD   = m2r | mw;
        bus.RegDstD   = rw & ~m2r;
        bus.ALUOpD    = aluop;
        bus.RsD       = rs;
        bus.RtD       = rt;
        bus.RdD       = rd;
        bus.RD1D      = rd1;
        bus.RD2D      = rd2;
        bus.SignImmD  = {16'h0, rd, 11'h0};
        bus.FlushE    = flush;
    endtask

    // One clock: check StallD now, push expected, clock, pop and compare.
    task automatic cycle(input string tag, input bit chk_stall);
        logic exp_stall;
        exp_t x;
        exp_t got;
        #1;
        exp_stall = bus.ValidD & m_e.valid & m_e.mem_to_reg & m_e.reg_write &
                    (m_e.rt != 5'd0) & ((m_e.rt == bus.RsD) | (m_e.rt == bus.RtD));
        if (chk_stall) check({tag, "_stall"}, 128'(bus.StallD), 128'(exp_stall));
        x.e   = m_e;
        x.cnt = m_cnt;
        if (!rst_n) begin
            x.e   = '0;
            x.cnt = '0;
        end else if (bus.FlushE | exp_stall) begin
            x.e = '0;
            if (m_cnt != '1) x.cnt = m_cnt + CNT_W'(1);
        end else begin
            x.e = d_now();
        end
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 128'(1), 128'(0));
        end else begin
            x = sb_q.pop_front();
            got.e   = e_now();
            got.cnt = bus.BubbleCount;
            check({tag, "_e"}, 128'(got.e), 128'(x.e));
            check({tag, "_cnt"}, 128'(got.cnt), 128'(x.cnt));
            m_e   = x.e;
            m_cnt = x.cnt;
        end
        @(negedge clk);
    endtask

    initial begin
        m_e   = '0;
        m_cnt = '0;
        rst_n = 1'b0;
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);

        // Reset with nonzero D inputs
        set_d(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        cycle("rst0", 1'b0);
        cycle("rst1", 1'b1);
        check("rst_valid", 128'(bus.ValidE), 128'(0));
        check("rst_cnt", 128'(bus.BubbleCount), 128'(0));
        rst_n = 1'b1;

        // Pass-through R-type add
        set_d(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd9, 5'd10, 5'd11, 32'h11, 32'h22, 1'b0);
        cycle("pass", 1'b1);
        check("pass_valid", 128'(bus.ValidE), 128'(1));
        check("pass_rd", 128'(bus.RdE), 128'(11));
        check("pass_rd2", 128'(bus.RD2E), 128'(32'h22));

        // Load-use on rs, then on rt
        for (int k = 0; k < 2; k++) begin
            set_d(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 5'd29, 5'd8, 5'd0, 32'h100, 32'h0, 1'b0);
            cycle("lw", 1'b1);
            if (k == 0) set_d(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd8, 5'd12, 5'd13, 32'h5, 32'h6, 1'b0);
            else        set_d(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd12, 5'd8, 5'd13, 32'h5, 32'h6, 1'b0);
            #1 check("lu_stall_hi", 128'(bus.StallD), 128'(1));
            cycle("lu_bubble", 1'b1);
            check("lu_valid0", 128'(bus.ValidE), 128'(0));
            check("lu_stall_lo", 128'(bus.StallD), 128'(0));
            cycle("lu_held", 1'b1);
            check("lu_captured", 128'(k == 0 ? bus.RsE : bus.RtE), 128'(8));
        end
        check("lu_cnt2", 128'(bus.BubbleCount), 128'(2));

        // No false stall: lw to $0, and invalid decode
        set_d(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 5'd29, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        cycle("lw0", 1'b1);
        set_d(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd0, 5'd3, 5'd4, 32'h1, 32'h2, 1'b0);
        cycle("nfs0", 1'b1);
        set_d(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 5'd29, 5'd8, 5'd0, 32'h0, 32'h0, 1'b0);
        cycle("lw8", 1'b1);
        set_d(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 5'd8, 5'd3, 5'd4, 32'h1, 32'h2, 1'b0);
        cycle("nfs1", 1'b1);
        check("nfs_cnt", 128'(bus.BubbleCount), 128'(2));

        // Flush with a valid beq (MemWrite asserted to prove it is cleared)
        set_d(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 5'd1, 5'd2, 5'd0, 32'h7, 32'h7, 1'b1);
        cycle("flush", 1'b1);
        check("flush_memwr", 128'(bus.MemWriteE), 128'(0));
        check("flush_cnt", 128'(bus.BubbleCount), 128'(3));

        // Flush coincident with load-use: one bubble only
        set_d(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 5'd29, 5'd8, 5'd0, 32'h0, 32'h0, 1'b0);
        cycle("lw_f", 1'b1);
        set_d(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd8, 5'd3, 5'd4, 32'h1, 32'h2, 1'b1);
        cycle("flush_lu", 1'b1);
        check("flush_lu_cnt", 128'(bus.BubbleCount), 128'(4));

        // Saturation: 20 consecutive flushes
        set_d(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1'b1);
        for (int i = 0; i < 20; i++) cycle("sat", 1'b1);
        check("sat_cnt", 128'(bus.BubbleCount), 128'(4'hF));
        cycle("sat_hold", 1'b1);
        check("sat_hold_cnt", 128'(bus.BubbleCount), 128'(4'hF));

        // Reset during a load-use stall cycle
        set_d(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 5'd29, 5'd8, 5'd0, 32'h0, 32'h0, 1'b0);
        cycle("lw_r", 1'b1);
        set_d(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 5'd8, 5'd3, 5'd4, 32'h1, 32'h2, 1'b0);
        rst_n = 1'b0;
        cycle("rst_stall", 1'b1);
        rst_n = 1'b1;
        check("rst_stall_cnt", 128'(bus.BubbleCount), 128'(0));
        check("rst_stall_lo", 128'(bus.StallD), 128'(0));
        cycle("post_rst", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
